// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO that feeds a UART transmitter one byte at a time.
// The CPU side pushes bytes with a single-cycle strobe. The launch sequencer
// pops one byte, pulses begin_flag, waits for busy_flag to rise and then fall,
// and returns to IDLE before the next launch. If busy never rises, the byte
// is abandoned and a sticky timeout is raised.
module uart_tx_fifo #(
  parameter int DEPTH        = 16,
  parameter int ADDR_W       = 4,
  parameter int BUSY_TIMEOUT = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [7:0]        wr_data,
  input  logic              clear,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic              timeout,
  output logic              tx_en,
  output logic              begin_flag,
  output logic [7:0]        tx_data,
  input  logic              busy_flag
);

  localparam int TIMER_W = $clog2(BUSY_TIMEOUT + 1);
  localparam logic [ADDR_W:0]    FULL_CNT   = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0]    CNT_ZERO   = {(ADDR_W + 1){1'b0}};
  localparam logic [ADDR_W:0]    CNT_ONE    = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W-1:0]  PTR_ZERO   = {ADDR_W{1'b0}};
  localparam logic [ADDR_W-1:0]  PTR_ONE    = ADDR_W'(1);
  localparam logic [TIMER_W-1:0] TIMER_ZERO = {TIMER_W{1'b0}};
  localparam logic [TIMER_W-1:0] TIMER_ONE  = TIMER_W'(1);
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(BUSY_TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LAUNCH    = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;

  logic [7:0]         mem_r [DEPTH];
  logic [ADDR_W-1:0]  wr_ptr_r;
  logic [ADDR_W-1:0]  rd_ptr_r;
  logic [ADDR_W:0]    count_r;
  logic               full_r;
  logic               empty_r;
  logic               overflow_r;
  logic               timeout_r;
  logic               tx_en_r;
  logic               begin_r;
  logic [7:0]         tx_data_r;
  logic [TIMER_W-1:0] timer_r;
  state_t             state_r;

  logic               wr_acc_s;
  logic               pop_s;
  logic               timeout_hit_s;
  logic [ADDR_W:0]    count_nxt_s;

  // Accept/pop decisions and next occupancy; clear flushes and blocks both.
  always_comb begin
    wr_acc_s      = 1'b0;
    pop_s         = 1'b0;
    timeout_hit_s = 1'b0;
    count_nxt_s   = count_r;
    // A write is judged against the registered full flag, so a pop in the
    // same cycle never makes room for it.
    if (wr_en && !full_r && !clear) begin
      wr_acc_s = 1'b1;
    end else begin
      wr_acc_s = 1'b0;
    end
    if ((state_r == IDLE) && !empty_r && !busy_flag && !clear) begin
      pop_s = 1'b1;
    end else begin
      pop_s = 1'b0;
    end
    if ((state_r == WAIT_BUSY) && !busy_flag && (timer_r == TIMER_LAST)) begin
      timeout_hit_s = 1'b1;
    end else begin
      timeout_hit_s = 1'b0;
    end
    if (clear) begin
      count_nxt_s = CNT_ZERO;
    end else if (wr_acc_s && !pop_s) begin
      count_nxt_s = count_r + CNT_ONE;
    end else if (!wr_acc_s && pop_s) begin
      count_nxt_s = count_r - CNT_ONE;
    end else begin
      count_nxt_s = count_r;
    end
  end

  // Byte storage; contents need no reset because occupancy guards every read.
  always_ff @(posedge clk) begin
    if (wr_acc_s) begin
      mem_r[wr_ptr_r] <= wr_data;
    end
  end

  // Circular-buffer pointers, wrapping naturally at DEPTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= PTR_ZERO;
      rd_ptr_r <= PTR_ZERO;
    end else if (clear) begin
      wr_ptr_r <= PTR_ZERO;
      rd_ptr_r <= PTR_ZERO;
    end else begin
      if (wr_acc_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
    end
  end

  // Registered occupancy, full/empty and sticky error flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r    <= CNT_ZERO;
      full_r     <= 1'b0;
      empty_r    <= 1'b1;
      overflow_r <= 1'b0;
      timeout_r  <= 1'b0;
    end else begin
      count_r <= count_nxt_s;
      full_r  <= (count_nxt_s == FULL_CNT);
      empty_r <= (count_nxt_s == CNT_ZERO);
      if (clear) begin
        overflow_r <= 1'b0;
        timeout_r  <= 1'b0;
      end else begin
        if (wr_en && full_r) begin
          overflow_r <= 1'b1;
        end
        if (timeout_hit_s) begin
          timeout_r <= 1'b1;
        end
      end
    end
  end

  // Transmitter enable rises on the first edge after reset and stays high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_en_r <= 1'b0;
    end else begin
      tx_en_r <= 1'b1;
    end
  end

  // Launch sequencer; tx_data only changes on a launch, so it is stable
  // for the whole frame. clear does not disturb a frame in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      begin_r   <= 1'b0;
      tx_data_r <= 8'h00;
      timer_r   <= TIMER_ZERO;
    end else begin
      case (state_r)
        IDLE: begin
          if (pop_s) begin
            state_r   <= LAUNCH;
            tx_data_r <= mem_r[rd_ptr_r];
            begin_r   <= 1'b1;
          end else begin
            begin_r   <= 1'b0;
          end
        end
        LAUNCH: begin
          begin_r <= 1'b0;
          timer_r <= TIMER_ZERO;
          state_r <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          begin_r <= 1'b0;
          if (busy_flag) begin
            state_r <= WAIT_DONE;
          end else if (timeout_hit_s) begin
            timer_r <= TIMER_ZERO;
            state_r <= IDLE;
          end else begin
            timer_r <= timer_r + TIMER_ONE;
          end
        end
        WAIT_DONE: begin
          begin_r <= 1'b0;
          if (!busy_flag) begin
            state_r <= IDLE;
          end
        end
        default: begin
          begin_r <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign full       = full_r;
  assign empty      = empty_r;
  assign count      = count_r;
  assign overflow   = overflow_r;
  assign timeout    = timeout_r;
  assign tx_en      = tx_en_r;
  assign begin_flag = begin_r;
  assign tx_data    = tx_data_r;

endmodule
